display_scan: RTL and testbench
===============================

Name: display_scan

Overview:
- Upstream neighbour of the 4-digit anode decoder in the coffee-maker front panel.
- Accepts a 4-digit BCD value, double-buffers it, and time-multiplexes the display by stepping a 2-bit digit index that drives the anode decoder.
- Emits registered active-low segment and decimal-point data aligned with the decoder's one-cycle registered output.
- Handles frame-synchronous value update, leading-zero blanking and global blanking.

Parameters:
DIV_WIDTH, 16, width of the refresh prescaler counter
DIV_MAX, 49999, prescaler terminal count; digit dwell = DIV_MAX+1 clk cycles
LZ_BLANK, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
load  in  1  single-cycle strobe; capture value_in/dp_in into pending buffer
value_in  in  16  four BCD nibbles, [15:12]=digit3 (leftmost) .. [3:0]=digit0
dp_in  in  4  decimal point per digit, bit i = digit i, 1 = lit
blank  in  1  1 = all segments and dp dark
digit_sel  out  2  current digit index, to anode decoder input
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point, active-low
load_ack  out  1  one-cycle pulse when pending buffer is committed to display
frame_start  out  1  one-cycle pulse when digit_sel wraps 3->0

Behaviour:
- Reset (rst_n=0, asynchronous) values:
  - prescaler=0, digit_sel=0, active and pending buffers=0, pend flag=0.
  - seg_n=7'h7F, dp_n=1, load_ack=0, frame_start=0.
- Prescaler:
  - Counts 0..DIV_MAX then wraps to 0.
  - tick = (count==DIV_MAX).
  - On tick, digit_sel <= digit_sel+1 mod 4.
- Frame boundary: a tick while digit_sel==3.
  - On the boundary edge, digit_sel becomes 0 and frame_start pulses high for exactly that following cycle.
- Load buffering:
  - load=1 captures value_in and dp_in into pending and sets pend.
  - A load while pend=1 overwrites pending (latest wins).
  - At a frame boundary with pend=1: active <= pending, pend cleared, load_ack high for one cycle, coincident with frame_start.
  - Without pend, active is unchanged and load_ack stays 0.
- Simultaneous load and frame boundary in the same cycle:
  - The previously pending value (if any) commits.
  - The new value is stored in pending, with pend=1 after the edge.
  - The new value commits at the next boundary.
- Segment path (registered):
  - seg_n/dp_n are computed from active nibble[digit_sel] and registered.
  - They therefore change one clk after digit_sel changes, the same edge the anode decoder output changes.
  - Latency from digit_sel change to matching seg_n = 1 cycle.
- BCD to segments (seg_n hex):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10.
  - Nibbles A-F show a dash: 3F (g only).
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k (k=3..1) is blanked (seg_n=7F) when its nibble and every higher nibble are 0.
  - Digit 0 is never blanked.
  - dp of a blanked digit follows dp_in normally.
- blank=1 forces seg_n=7F and dp_n=1 on the next registered cycle. Scanning, buffering and pulses continue unaffected.
- Reset mid-frame returns all state to reset values immediately. A pending value is discarded.

Test Plan:
- Reset, DIV_MAX=3: hold rst_n=0 -> seg_n=7F, dp_n=1, digit_sel=0. Release -> digit_sel steps 0,1,2,3,0 every 4 clk; frame_start pulses on each 3->0.
- Load value_in=16'h1234, dp_in=4'b0100 mid-frame -> no change until boundary; then load_ack+frame_start pulse. Next frame seg_n per digit 0..3 = 19,30,24,79, each 1 clk after digit_sel. dp_n=0 only on digit 2.
- Load 16'h0070 with LZ_BLANK=1 -> digit3=7F, digit2=7F, digit1=78, digit0=40. With LZ_BLANK=0 -> digit3=40, digit2=40.
- Two loads (16'h1111 then 16'h2222) in one frame -> single load_ack; display shows 2 on all digits (seg_n=24).
- load of 16'h5555 in the same cycle as a frame boundary with prior pending 16'h9999 -> 9999 commits now (seg_n=10), 5555 commits at the next boundary (seg_n=12).
- blank=1 for 2 frames while scanning value 16'h8888 -> seg_n=7F, dp_n=1 throughout, digit_sel still cycling. blank=0 -> seg_n=00 on the next cycle. Assert rst_n=0 mid-frame -> outputs return to reset values asynchronously.

Source files
------------

// File: rtl/display_scan.sv
// 4-digit BCD display scanner: double-buffers a value, steps the digit index for
// the anode decoder, and registers active-low segment/dp data aligned to it.
module display_scan #(
  parameter int unsigned DIV_WIDTH = 16,
  parameter int unsigned DIV_MAX   = 49999,
  parameter int unsigned LZ_BLANK  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [1:0]  digit_sel,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic        load_ack,
  output logic        frame_start
);

  localparam int unsigned VAL_W = 16;
  localparam int unsigned DP_W  = 4;

  logic [DIV_WIDTH-1:0] cnt;
  logic [VAL_W-1:0]     active_val;
  logic [VAL_W-1:0]     pend_val;
  logic [DP_W-1:0]      active_dp;
  logic [DP_W-1:0]      pend_dp;
  logic                 pend;

  logic       tick;
  logic       boundary;
  logic [3:0] nib;
  logic       lz;
  logic [6:0] seg_c;
  logic       dp_c;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  assign tick     = (cnt == DIV_WIDTH'(DIV_MAX));
  assign boundary = tick && (digit_sel == 2'd3);

  // Select the current nibble and decide whether it is a leading zero.
  always_comb begin
    nib = 4'd0;
    lz  = 1'b0;
    case (digit_sel)
      2'd0: nib = active_val[3:0];
      2'd1: begin
        nib = active_val[7:4];
        lz  = (active_val[15:4] == 12'd0);
      end
      2'd2: begin
        nib = active_val[11:8];
        lz  = (active_val[15:8] == 8'd0);
      end
      default: begin
        nib = active_val[15:12];
        lz  = (active_val[15:12] == 4'd0);
      end
    endcase

    seg_c = bcd_to_seg(nib);
    if (blank || (lz && (LZ_BLANK != 0))) begin
      seg_c = 7'h7F;
    end
    dp_c = blank | ~active_dp[digit_sel];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      digit_sel   <= 2'd0;
      active_val  <= '0;
      active_dp   <= '0;
      pend_val    <= '0;
      pend_dp     <= '0;
      pend        <= 1'b0;
      seg_n       <= 7'h7F;
      dp_n        <= 1'b1;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= tick ? '0 : cnt + DIV_WIDTH'(1);
      frame_start <= boundary;
      load_ack    <= boundary && pend;
      seg_n       <= seg_c;
      dp_n        <= dp_c;

      if (tick) begin
        digit_sel <= 2'(digit_sel + 2'd1);
      end

      // A boundary commits the value pending before this edge; a coincident
      // load becomes the new pending value for the following frame.
      if (boundary && pend) begin
        active_val <= pend_val;
        active_dp  <= pend_dp;
      end

      if (load) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
        pend     <= 1'b1;
      end else if (boundary) begin
        pend     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with a 4-cycle dwell; two instances cover
// leading-zero blanking enabled and disabled.
module tb_display_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        blank;

  logic [1:0]  digit_sel_a, digit_sel_b;
  logic [6:0]  seg_n_a, seg_n_b;
  logic        dp_n_a, dp_n_b;
  logic        load_ack_a, load_ack_b;
  logic        frame_start_a, frame_start_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  display_scan #(.DIV_WIDTH(16), .DIV_MAX(3), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .blank(blank), .digit_sel(digit_sel_a), .seg_n(seg_n_a), .dp_n(dp_n_a),
    .load_ack(load_ack_a), .frame_start(frame_start_a)
  );

  display_scan #(.DIV_WIDTH(16), .DIV_MAX(3), .LZ_BLANK(0)) dut_nolz (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in), .dp_in(dp_in),
    .blank(blank), .digit_sel(digit_sel_b), .seg_n(seg_n_b), .dp_n(dp_n_b),
    .load_ack(load_ack_b), .frame_start(frame_start_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load     = 1'b1;
    value_in = v;
    dp_in    = d;
    step(1);
    load     = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      seen = (frame_start_a === 1'b1);
    end
    chk("frame_start_seen", 16'(seen), 16'd1);
    chk("frame_start_b", 16'(frame_start_b), 16'd1);
  endtask

  // Called on the cycle frame_start is high; walks one frame of digits.
  task automatic check_scan(input string tag, input logic [27:0] sa,
                            input logic [27:0] sb, input logic [3:0] dpn);
    step(1);
    chk($sformatf("%s_sel0", tag), 16'(digit_sel_a), 16'd0);
    chk($sformatf("%s_seg0", tag), 16'(seg_n_a), 16'(sa[6:0]));
    chk($sformatf("%s_segb0", tag), 16'(seg_n_b), 16'(sb[6:0]));
    chk($sformatf("%s_dp0", tag), 16'(dp_n_a), 16'(dpn[0]));
    for (int k = 1; k < 4; k++) begin
      step(3);
      chk($sformatf("%s_sel%0d", tag, k), 16'(digit_sel_a), 16'(k));
      chk($sformatf("%s_selb%0d", tag, k), 16'(digit_sel_b), 16'(k));
      chk($sformatf("%s_lat%0d", tag, k), 16'(seg_n_a), 16'(sa[7*(k-1) +: 7]));
      step(1);
      chk($sformatf("%s_seg%0d", tag, k), 16'(seg_n_a), 16'(sa[7*k +: 7]));
      chk($sformatf("%s_segb%0d", tag, k), 16'(seg_n_b), 16'(sb[7*k +: 7]));
      chk($sformatf("%s_dp%0d", tag, k), 16'(dp_n_a), 16'(dpn[k]));
      chk($sformatf("%s_dpb%0d", tag, k), 16'(dp_n_b), 16'(dpn[k]));
    end
  endtask

  initial begin
    int frames;
    rst_n    = 1'b0;
    load     = 1'b0;
    value_in = 16'h0000;
    dp_in    = 4'h0;
    blank    = 1'b0;

    // Reset state
    step(3);
    chk("rst_seg", 16'(seg_n_a), 16'h7F);
    chk("rst_dp", 16'(dp_n_a), 16'd1);
    chk("rst_sel", 16'(digit_sel_a), 16'd0);
    chk("rst_ack", 16'(load_ack_a), 16'd0);
    chk("rst_fs", 16'(frame_start_a), 16'd0);

    // Scan sequence: digit advances every 4 cycles, wrap pulses frame_start
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step(1);
      chk($sformatf("scan_sel_%0d", n), 16'(digit_sel_a), 16'((n / 4) % 4));
      chk($sformatf("scan_fs_%0d", n), 16'(frame_start_a), 16'(n == 16));
    end

    // Mid-frame load of 1234 is invisible until the boundary
    step(6);
    do_load(16'h1234, 4'b0100);
    step(7);
    chk("pre_commit_seg", 16'(seg_n_a), 16'h7F);
    chk("pre_commit_segb", 16'(seg_n_b), 16'h40);
    chk("pre_commit_ack", 16'(load_ack_a), 16'd0);
    wait_frame();
    chk("ack_1234", 16'(load_ack_a), 16'd1);
    chk("ackb_1234", 16'(load_ack_b), 16'd1);
    check_scan("v1234", {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011);

    // Leading-zero blanking on 0070
    do_load(16'h0070, 4'b0000);
    wait_frame();
    chk("ack_0070", 16'(load_ack_a), 16'd1);
    check_scan("v0070", {7'h7F, 7'h7F, 7'h78, 7'h40}, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b1111);

    // Two loads in one frame: latest wins, single ack
    do_load(16'h1111, 4'b1111);
    do_load(16'h2222, 4'b0000);
    wait_frame();
    chk("ack_2222", 16'(load_ack_a), 16'd1);
    check_scan("v2222", {7'h24, 7'h24, 7'h24, 7'h24}, {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);
    wait_frame();
    chk("single_ack", 16'(load_ack_a), 16'd0);

    // Load coincident with boundary while 9999 is pending
    do_load(16'h9999, 4'b0000);
    step(14);
    do_load(16'h5555, 4'b0001);
    chk("coinc_fs", 16'(frame_start_a), 16'd1);
    chk("coinc_ack", 16'(load_ack_a), 16'd1);
    check_scan("v9999", {7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}, 4'b1111);
    wait_frame();
    chk("ack_5555", 16'(load_ack_a), 16'd1);
    check_scan("v5555", {7'h12, 7'h12, 7'h12, 7'h12}, {7'h12, 7'h12, 7'h12, 7'h12}, 4'b1110);

    // Global blanking for two frames over 8888 with all dps lit
    do_load(16'h8888, 4'b1111);
    wait_frame();
    chk("ack_8888", 16'(load_ack_a), 16'd1);
    blank  = 1'b1;
    frames = 0;
    for (int n = 0; n < 32; n++) begin
      step(1);
      chk($sformatf("blank_seg_%0d", n), 16'(seg_n_a), 16'h7F);
      chk($sformatf("blank_dp_%0d", n), 16'(dp_n_a), 16'd1);
      if (frame_start_a === 1'b1) frames++;
    end
    chk("blank_frames", 16'(frames), 16'd2);
    blank = 1'b0;
    step(1);
    chk("unblank_seg", 16'(seg_n_a), 16'h00);
    chk("unblank_dp", 16'(dp_n_a), 16'd0);

    // Asynchronous reset mid-frame discards a pending value
    do_load(16'h4444, 4'b0000);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_seg", 16'(seg_n_a), 16'h7F);
    chk("arst_dp", 16'(dp_n_a), 16'd1);
    chk("arst_sel", 16'(digit_sel_a), 16'd0);
    chk("arst_ack", 16'(load_ack_a), 16'd0);
    chk("arst_fs", 16'(frame_start_a), 16'd0);
    step(2);
    rst_n = 1'b1;
    wait_frame();
    chk("post_rst_ack", 16'(load_ack_a), 16'd0);
    step(1);
    chk("post_rst_seg0", 16'(seg_n_a), 16'h40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
